hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, tracked stages after decode (entry 0 = execute ... entry DEPTH-1 = writeback); legal range 1..8.
REQ-003 SHALL have parameter LOAD_FWD_STAGE, default 1, lowest entry index from which a load result is forwardable; legal range 0..DEPTH-1.
REQ-004 SHALL have parameter CW, default 16, event-counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port issue_valid_i  input  1  decode instruction is valid.
REQ-008 SHALL have port issue_rd_i  input  AW  destination register of decode instruction.
REQ-009 SHALL have port issue_regwrite_i  input  1  decode instruction writes rd.
REQ-010 SHALL have port issue_load_i  input  1  decode instruction is a load.
REQ-011 SHALL have ports rs1_i, rs2_i  input  AW each  decode source registers.
REQ-012 SHALL have ports rs1_use_i, rs2_use_i  input  1 each  source actually read.
REQ-013 SHALL have port branch_taken_i  input  1  taken branch/jump resolved in entry 0.
REQ-014 SHALL have port stall_o  output  1  hold PC and fetch/decode registers.
REQ-015 SHALL have port flush_o  output  1  kill fetch/decode instructions.
REQ-016 SHALL have ports fwd1_sel_o, fwd2_sel_o  output  $clog2(DEPTH+1) each  0 = register file, k+1 = result of entry k.
REQ-017 SHALL have ports stall_cnt_o, flush_cnt_o  output  CW each  event counters.

Function
REQ-018 SHALL hold DEPTH entries {valid, rd, regwrite, load}; every clock entry k <= entry k-1 for k>=1.
REQ-019 Entry 0 SHALL load the decode instruction when issue_valid_i=1, stall_o=0, flush_o=0; otherwise a bubble (valid=0).
REQ-020 An entry SHALL match source rsN when valid=1, regwrite=1, rd==rsN, rsN!=0, rsN_use_i=1.
REQ-021 fwdN_sel_o SHALL be k+1 for the lowest-index matching entry k (youngest wins), else 0; combinational from state and inputs.
REQ-022 stall_o SHALL be 1 when the youngest match for either source has load=1 and k<LOAD_FWD_STAGE; fwd selects are then 0.
REQ-023 flush_o SHALL equal branch_taken_i combinationally.
REQ-024 flush_o=1 together with a stall condition: flush wins, stall_o=0, entry 0 gets a bubble.
REQ-025 The entry holding the branch SHALL advance normally on flush; older entries are never killed.
REQ-026 stall_cnt_o SHALL increment each clock stall_o=1; flush_cnt_o each clock flush_o=1; both saturate at 2^CW-1.
REQ-027 Register x0 SHALL never produce a forward or stall.

Reset
REQ-028 rst=0 SHALL asynchronously clear all entry valid bits and both counters.
REQ-029 While rst=0 and after release: stall_o=0, fwd1_sel_o=fwd2_sel_o=0 (absent new issue), flush_o follows branch_taken_i.
REQ-030 Reset asserted mid-stall SHALL drop stall_o to 0 immediately; first edge after release accepts a fresh issue.

Verification (DEPTH=3, LOAD_FWD_STAGE=1, CW=4)
REQ-031 Issue add rd=5; next three cycles decode rs1=5, use=1, no other writers -> fwd1_sel_o = 1, 2, 3, then 0.
REQ-032 Issue load rd=6; next cycle rs2=6 -> stall_o=1 for exactly 1 cycle, then fwd2_sel_o=2; stall_cnt_o=1.
REQ-033 Writers rd=7 in entries 0 and 1, decode rs1=7 -> fwd1_sel_o=1; writer rd=0 with rs1=0 -> fwd1_sel_o=0, stall_o=0.
REQ-034 Load-use stall condition plus branch_taken_i=1 same cycle -> flush_o=1, stall_o=0, entry 0 bubble next cycle, flush_cnt_o +1.
REQ-035 Hold stall condition 20 cycles (repeat load-use) -> stall_cnt_o saturates at 15, no wrap.
REQ-036 Assert rst=0 mid-stall with entries full -> stall_o=0 immediately, counters 0, all selects 0 after release.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers. Issues a load-use stall, a branch flush and
// forwarding selects, all combinational from state and inputs. Counters register stall/flush cycles.
module hazard_scoreboard #(
  parameter int AW             = 5,
  parameter int DEPTH          = 3,
  parameter int LOAD_FWD_STAGE = 1,
  parameter int CW             = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid_i,
  input  logic [AW-1:0]                issue_rd_i,
  input  logic                         issue_regwrite_i,
  input  logic                         issue_load_i,
  input  logic [AW-1:0]                rs1_i,
  input  logic [AW-1:0]                rs2_i,
  input  logic                         rs1_use_i,
  input  logic                         rs2_use_i,
  input  logic                         branch_taken_i,
  output logic                         stall_o,
  output logic                         flush_o,
  output logic [$clog2(DEPTH+1)-1:0]   fwd1_sel_o,
  output logic [$clog2(DEPTH+1)-1:0]   fwd2_sel_o,
  output logic [CW-1:0]                stall_cnt_o,
  output logic [CW-1:0]                flush_cnt_o
);

  localparam int SW = $clog2(DEPTH+1);
  localparam logic [SW-1:0] LOAD_FWD = SW'(LOAD_FWD_STAGE);

  logic [DEPTH-1:0]         entValid;
  logic [DEPTH-1:0]         entRegwrite;
  logic [DEPTH-1:0]         entLoad;
  logic [DEPTH-1:0][AW-1:0] entRd;

  logic          hit1, hit2, load1, load2;
  logic [SW-1:0] idx1, idx2;
  logic          stallCond;

  // Scan oldest to youngest so the lowest-index match overwrites the rest.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    load1 = 1'b0;
    load2 = 1'b0;
    idx1  = '0;
    idx2  = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (entValid[k] && entRegwrite[k] && rs1_use_i && rs1_i != '0 && entRd[k] == rs1_i) begin
        hit1  = 1'b1;
        idx1  = SW'(k);
        load1 = entLoad[k];
      end
      if (entValid[k] && entRegwrite[k] && rs2_use_i && rs2_i != '0 && entRd[k] == rs2_i) begin
        hit2  = 1'b1;
        idx2  = SW'(k);
        load2 = entLoad[k];
      end
    end
  end

  assign stallCond = (hit1 && load1 && idx1 < LOAD_FWD) || (hit2 && load2 && idx2 < LOAD_FWD);
  assign flush_o   = branch_taken_i;
  assign stall_o   = stallCond && !flush_o;

  // A load result that is not yet available is never forwarded, even when a flush masks the stall.
  assign fwd1_sel_o = (hit1 && !stallCond) ? idx1 + SW'(1) : '0;
  assign fwd2_sel_o = (hit2 && !stallCond) ? idx2 + SW'(1) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entValid    <= '0;
      entRegwrite <= '0;
      entLoad     <= '0;
      entRd       <= '0;
    end else begin
      entValid[0]    <= issue_valid_i && !stall_o && !flush_o;
      entRegwrite[0] <= issue_regwrite_i;
      entLoad[0]     <= issue_load_i;
      entRd[0]       <= issue_rd_i;
      for (int k = 1; k < DEPTH; k++) begin
        entValid[k]    <= entValid[k-1];
        entRegwrite[k] <= entRegwrite[k-1];
        entLoad[k]     <= entLoad[k-1];
        entRd[k]       <= entRd[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && stall_cnt_o != {CW{1'b1}}) stall_cnt_o <= stall_cnt_o + CW'(1);
      if (flush_o && flush_cnt_o != {CW{1'b1}}) flush_cnt_o <= flush_cnt_o + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector table plus hand sequences for counter saturation and reset mid-stall.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       issueValid, issueRegwrite, issueLoad;
  logic [4:0] issueRd, rs1, rs2;
  logic       rs1Use, rs2Use, branchTaken;
  logic       stall, flush;
  logic [1:0] fwd1Sel, fwd2Sel;
  logic [3:0] stallCnt, flushCnt;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.AW(5), .DEPTH(3), .LOAD_FWD_STAGE(1), .CW(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid_i    (issueValid),
    .issue_rd_i       (issueRd),
    .issue_regwrite_i (issueRegwrite),
    .issue_load_i     (issueLoad),
    .rs1_i            (rs1),
    .rs2_i            (rs2),
    .rs1_use_i        (rs1Use),
    .rs2_use_i        (rs2Use),
    .branch_taken_i   (branchTaken),
    .stall_o          (stall),
    .flush_o          (flush),
    .fwd1_sel_o       (fwd1Sel),
    .fwd2_sel_o       (fwd2Sel),
    .stall_cnt_o      (stallCnt),
    .flush_cnt_o      (flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       iv;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
    bit [4:0] r1;
    bit       u1;
    bit [4:0] r2;
    bit       u2;
    bit       br;
    bit       eStall;
    bit       eFlush;
    int       eF1;
    int       eF2;
    int       eSc;
    int       eFc;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit iv, input bit [4:0] rd, input bit rw, input bit ld,
                       input bit [4:0] r1, input bit u1, input bit [4:0] r2, input bit u2,
                       input bit br);
    issueValid    = iv;
    issueRd       = rd;
    issueRegwrite = rw;
    issueLoad     = ld;
    rs1           = r1;
    rs1Use        = u1;
    rs2           = r2;
    rs2Use        = u2;
    branchTaken   = br;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expSc;
    // fields: iv rd rw ld | rs1 use1 rs2 use2 | br | stall flush fwd1 fwd2 stallCnt flushCnt
    vecs[0]  = '{1, 5, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 2, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 3, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 6, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 0,  0, 0, 6, 1, 0,  1, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0,  0, 0, 6, 1, 0,  0, 0, 0, 2, 1, 0};
    vecs[8]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0};
    vecs[9]  = '{1, 7, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0};
    vecs[10] = '{1, 7, 1, 0,  7, 1, 0, 0, 0,  0, 0, 1, 0, 1, 0};
    vecs[11] = '{1, 0, 1, 0,  7, 1, 0, 0, 0,  0, 0, 1, 0, 1, 0};
    vecs[12] = '{0, 0, 0, 0,  0, 1, 7, 1, 0,  0, 0, 0, 2, 1, 0};
    vecs[13] = '{1, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0};
    vecs[14] = '{0, 0, 0, 0,  0, 1, 0, 1, 0,  0, 0, 0, 0, 1, 0};
    vecs[15] = '{1, 9, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0};
    vecs[16] = '{1, 11, 1, 0, 9, 1, 0, 0, 1,  0, 1, 0, 0, 1, 0};
    vecs[17] = '{0, 0, 0, 0, 11, 1, 9, 1, 0,  0, 0, 0, 2, 1, 1};

    // Reset state, with flush following the branch input during reset.
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("rst stall", int'(stall), 0);
    chk("rst flush", int'(flush), 1);
    chk("rst fwd1", int'(fwd1Sel), 0);
    chk("rst fwd2", int'(fwd2Sel), 0);
    chk("rst stallCnt", int'(stallCnt), 0);
    chk("rst flushCnt", int'(flushCnt), 0);
    branchTaken = 1'b0;
    nextCycle();
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].iv, vecs[i].rd, vecs[i].rw, vecs[i].ld,
            vecs[i].r1, vecs[i].u1, vecs[i].r2, vecs[i].u2, vecs[i].br);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), int'(stall), int'(vecs[i].eStall));
      chk($sformatf("v%0d flush", i), int'(flush), int'(vecs[i].eFlush));
      chk($sformatf("v%0d fwd1", i), int'(fwd1Sel), vecs[i].eF1);
      chk($sformatf("v%0d fwd2", i), int'(fwd2Sel), vecs[i].eF2);
      chk($sformatf("v%0d stallCnt", i), int'(stallCnt), vecs[i].eSc);
      chk($sformatf("v%0d flushCnt", i), int'(flushCnt), vecs[i].eFc);
      nextCycle();
    end

    // Repeated load-use: stalls on every other cycle, 20 stalls in total; counter saturates at 15.
    expSc = 1;
    for (int i = 0; i < 40; i++) begin
      drive(1, 3, 1, 1, 3, 1, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("sat%0d stall", i), int'(stall), (i % 2 == 1) ? 1 : 0);
      if (stall && expSc < 15) expSc++;
      nextCycle();
    end
    @(negedge clk);
    chk("sat stallCnt", int'(stallCnt), 15);
    chk("sat model", expSc, 15);
    chk("sat flushCnt", int'(flushCnt), 1);

    // Fill all entries, then assert reset in the middle of a load-use stall.
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
    nextCycle();
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
    nextCycle();
    drive(1, 4, 1, 1, 0, 0, 0, 0, 0);
    nextCycle();
    drive(1, 0, 0, 0, 4, 1, 2, 1, 0);
    @(negedge clk);
    chk("pre-rst stall", int'(stall), 1);
    #1 rst = 1'b0;
    #1;
    chk("mid-rst stall", int'(stall), 0);
    chk("mid-rst stallCnt", int'(stallCnt), 0);
    chk("mid-rst flushCnt", int'(flushCnt), 0);
    chk("mid-rst fwd1", int'(fwd1Sel), 0);
    chk("mid-rst fwd2", int'(fwd2Sel), 0);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst stall", int'(stall), 0);
    chk("post-rst fwd1", int'(fwd1Sel), 0);
    chk("post-rst fwd2", int'(fwd2Sel), 0);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    nextCycle();
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    chk("post-rst issue fwd1", int'(fwd1Sel), 1);
    chk("post-rst stallCnt", int'(stallCnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
